// File: rtl/bin_conv_0_mul_pipe.sv
// rtl/bin_conv_0_mul_pipe.sv - pipelined signed/unsigned multiplier with optional saturation
// Stage 1 registers the raw product, middle stages retime it, the last stage clamps and flags.
module bin_conv_0_mul_pipe #(
   parameter int DIN0_WIDTH = 15,
   parameter int DIN1_WIDTH = 5,
   parameter int DOUT_WIDTH = 16,
   parameter int NUM_STAGE  = 3,
   parameter int SATURATE   = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic                  is_signed,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  ovf
);
   localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
   localparam logic [DOUT_WIDTH-1:0] U_MAX = '1;
   localparam logic [DOUT_WIDTH-1:0] S_MAX = U_MAX >> 1;
   localparam logic [DOUT_WIDTH-1:0] S_MIN = ~S_MAX;

   logic          stall;
   logic [PW-1:0] a_ext, b_ext, prod_c;
   logic [PW-1:0] fin_p;
   logic          fin_s, fin_v;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // Extending both operands to full width makes one PW x PW multiply correct in either mode.
   always_comb begin
      a_ext  = {{DIN1_WIDTH{is_signed & din0[DIN0_WIDTH-1]}}, din0};
      b_ext  = {{DIN0_WIDTH{is_signed & din1[DIN1_WIDTH-1]}}, din1};
      prod_c = a_ext * b_ext;
   end

   generate
      if (NUM_STAGE == 1) begin : g_single
         assign fin_p = prod_c;
         assign fin_s = is_signed;
         assign fin_v = in_valid;
      end else begin : g_multi
         logic [PW-1:0]        p_q [NUM_STAGE-1];
         logic [NUM_STAGE-2:0] s_q;
         logic [NUM_STAGE-2:0] v_q;

         always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
               v_q <= '0;
            end else if (!stall) begin
               v_q[0] <= in_valid;
               for (int k = 1; k < NUM_STAGE - 1; k++) v_q[k] <= v_q[k-1];
            end
         end

         always_ff @(posedge ap_clk) begin
            if (!stall) begin
               p_q[0] <= prod_c;
               s_q[0] <= is_signed;
               for (int k = 1; k < NUM_STAGE - 1; k++) begin
                  p_q[k] <= p_q[k-1];
                  s_q[k] <= s_q[k-1];
               end
            end
         end

         assign fin_p = p_q[NUM_STAGE-2];
         assign fin_s = s_q[NUM_STAGE-2];
         assign fin_v = v_q[NUM_STAGE-2];
      end
   endgenerate

   logic signed [PW-1:0]   top_s;
   logic                   ovf_c;
   logic [DOUT_WIDTH-1:0]  dout_c;

   // Signed fit: every bit from DOUT_WIDTH-1 upward must equal the sign bit.
   always_comb begin
      top_s  = $signed(fin_p) >>> (DOUT_WIDTH - 1);
      if (fin_s) ovf_c = !((top_s == '0) || (&top_s));
      else       ovf_c = |(fin_p >> DOUT_WIDTH);
      dout_c = fin_p[DOUT_WIDTH-1:0];
      if (SATURATE != 0 && ovf_c) begin
         if (!fin_s)             dout_c = U_MAX;
         else if (fin_p[PW-1])   dout_c = S_MIN;
         else                    dout_c = S_MAX;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         out_valid <= 1'b0;
         dout      <= '0;
         ovf       <= 1'b0;
      end else if (!stall) begin
         out_valid <= fin_v;
         if (fin_v) begin
            dout <= dout_c;
            ovf  <= ovf_c;
         end
      end
   end
endmodule

// File: tb/tb_bin_conv_0_mul_pipe.sv
// tb/tb_bin_conv_0_mul_pipe.sv - directed and streaming checks of bin_conv_0_mul_pipe
module tb_bin_conv_0_mul_pipe;
   logic        clk = 0;
   logic        rst;
   logic        in_valid, out_ready, is_signed;
   logic [14:0] din0;
   logic [4:0]  din1;
   logic        in_ready0, in_ready1, in_ready2;
   logic        out_valid0, out_valid1, out_valid2;
   logic [15:0] dout0, dout1;
   logic [19:0] dout2;
   logic        ovf0, ovf1, ovf2;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   bin_conv_0_mul_pipe #(.SATURATE(0)) u_wrap (
      .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .din0(din0), .din1(din1), .is_signed(is_signed), .out_valid(out_valid0),
      .out_ready(out_ready), .dout(dout0), .ovf(ovf0));

   bin_conv_0_mul_pipe #(.SATURATE(1)) u_sat (
      .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .din0(din0), .din1(din1), .is_signed(is_signed), .out_valid(out_valid1),
      .out_ready(out_ready), .dout(dout1), .ovf(ovf1));

   bin_conv_0_mul_pipe #(.DOUT_WIDTH(20), .NUM_STAGE(1)) u_one (
      .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .din0(din0), .din1(din1), .is_signed(is_signed), .out_valid(out_valid2),
      .out_ready(out_ready), .dout(dout2), .ovf(ovf2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: returns {ovf, dout} for the 16-bit result, wrap or saturate.
   function automatic logic [16:0] model(input logic [14:0] a, input logic [4:0] b,
                                         input logic s, input bit sat);
      longint av, bv, p;
      logic [63:0] pu;
      logic        o;
      logic [15:0] d;
      av = s ? longint'($signed(a)) : longint'(a);
      bv = s ? longint'($signed(b)) : longint'(b);
      p  = av * bv;
      o  = s ? (p < -32768 || p > 32767) : (p > 65535);
      pu = p;
      d  = pu[15:0];
      if (sat && o) d = s ? ((p < 0) ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
      return {o, d};
   endfunction

   task automatic directed(input string tag, input logic [14:0] a, input logic [4:0] b,
                           input logic s, input logic [15:0] exp_wrap,
                           input logic [15:0] exp_sat, input logic exp_ovf);
      din0 = a; din1 = b; is_signed = s; in_valid = 1; out_ready = 1;
      tick();
      in_valid = 0;
      check({tag, "_lat1"}, out_valid0, 0);
      tick();
      check({tag, "_lat2"}, out_valid0, 0);
      tick();
      check({tag, "_valid"}, out_valid0, 1);
      check({tag, "_wrap"}, dout0, exp_wrap);
      check({tag, "_sat"}, dout1, exp_sat);
      check({tag, "_ovf_w"}, ovf0, exp_ovf);
      check({tag, "_ovf_s"}, ovf1, exp_ovf);
      tick();
   endtask

   task automatic stream(input string tag, input int n, input int hold_start, input int hold_len);
      logic [16:0] q0[$];
      logic [16:0] q1[$];
      logic [16:0] e;
      logic [15:0] held;
      int sent = 0, got = 0, cyc = 0;
      held = 0;
      while (got < n && cyc < n + hold_len + 50) begin
         if (sent < n) begin
            din0 = 15'($urandom); din1 = 5'($urandom); is_signed = 1'($urandom);
            in_valid = 1;
         end else begin
            in_valid = 0;
         end
         out_ready = !(cyc >= hold_start && cyc < hold_start + hold_len);
         #1;
         if (!out_ready && out_valid0) begin
            check({tag, "_hold_in_ready"}, in_ready0, 0);
            if (cyc == hold_start) held = dout0;
            else check({tag, "_hold_dout"}, dout0, held);
         end
         if (in_valid && in_ready0) begin
            q0.push_back(model(din0, din1, is_signed, 0));
            q1.push_back(model(din0, din1, is_signed, 1));
            sent++;
         end
         if (out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
               check({tag, "_unexpected_out"}, 1, 0);
            end else begin
               e = q0.pop_front();
               check({tag, "_wrap"}, {ovf0, dout0}, e);
               e = q1.pop_front();
               check({tag, "_sat"}, {ovf1, dout1}, e);
            end
            got++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid  = 0;
      out_ready = 1;
      check({tag, "_count"}, got, n);
      check({tag, "_cycles"}, cyc, n + 3 + hold_len);
   endtask

   initial begin
      rst = 1; in_valid = 0; out_ready = 1; din0 = 0; din1 = 0; is_signed = 0;
      repeat (3) tick();
      rst = 0;
      check("rst_out_valid", out_valid0, 0);
      check("rst_dout", dout0, 0);
      check("rst_ovf", ovf0, 0);
      check("rst_in_ready", in_ready0, 1);

      // NUM_STAGE=1 copy sees the first directed vector one cycle after accept
      din0 = 15'h7FFF; din1 = 5'h1F; is_signed = 0; in_valid = 1;
      tick();
      in_valid = 0;
      check("one_valid", out_valid2, 1);
      check("one_dout", dout2, 20'hF7FE1);
      check("one_ovf", ovf2, 0);
      repeat (4) tick();

      directed("uns_max", 15'h7FFF, 5'h1F, 0, 16'h7FE1, 16'hFFFF, 1);
      directed("sgn_neg1", 15'h4000, 5'h1F, 1, 16'h4000, 16'h4000, 0);
      directed("sgn_min", 15'h4000, 5'h0F, 1, 16'h4000, 16'h8000, 1);
      directed("zero", 15'h0000, 5'h1F, 1, 16'h0000, 16'h0000, 0);

      stream("stream", 100, 1000, 0);
      repeat (4) tick();
      stream("bp", 60, 20, 5);
      repeat (4) tick();

      // Three results in flight, then reset
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         din0 = 15'(100 + i); din1 = 5'(3); is_signed = 0; in_valid = 1;
         tick();
      end
      in_valid = 0;
      check("mid_full", out_valid0, 1);
      rst = 1;
      tick();
      rst = 0;
      out_ready = 1;
      check("mid_rst_valid", out_valid0, 0);
      check("mid_rst_dout", dout0, 0);
      check("mid_rst_ovf", ovf0, 0);
      check("mid_rst_in_ready", in_ready0, 1);
      directed("post_rst", 15'h0123, 5'h05, 0, 16'h05AF, 16'h05AF, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
